// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - Johnson code sampler: phase decode, sequence checking, lock and error count
// Registered decode of an N-bit Johnson code into 2N phases with legality, step and lock tracking.
module johnson_phase_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N-1:0]               jc_in,
  output logic [$clog2(2*N)-1:0]     phase_idx,
  output logic [2*N-1:0]             phase_oh,
  output logic                       illegal,
  output logic                       seq_err,
  output logic                       wrap,
  output logic                       locked,
  output logic [7:0]                 err_cnt
);

  localparam int TWO_N = 2 * N;
  localparam int IW    = $clog2(TWO_N);
  localparam logic [IW-1:0] LAST_IDX = IW'(TWO_N - 1);
  localparam logic [3:0]    LOCK_V   = 4'(LOCK_CNT);

  typedef enum logic {UNLOCK, LOCK} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   phase_idx_q, phase_idx_d;
  logic [TWO_N-1:0] phase_oh_q, phase_oh_d;
  logic            illegal_q, illegal_d;
  logic            seq_err_q, seq_err_d;
  logic            wrap_q, wrap_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            has_prev_q, has_prev_d;
  logic [3:0]      run_q, run_d;

  logic [IW:0]     pop;
  logic [IW:0]     idx_full;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   succ;
  logic [N-1:0]    canon;
  logic            legal;

  // Canonical code for the decoded phase: ones from the LSB when MSB=0, zeros from the LSB when MSB=1.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + {{IW{1'b0}}, jc_in[i]};
    end
    idx_full = jc_in[N-1] ? ((IW+1)'(TWO_N) - pop) : pop;
    idx      = idx_full[IW-1:0];
    canon    = '0;
    for (int i = 0; i < N; i++) begin
      canon[i] = jc_in[N-1] ? ((i + int'(pop)) >= N) : (i < int'(pop));
    end
    legal = (canon == jc_in);
    succ  = (phase_idx_q == LAST_IDX) ? '0 : phase_idx_q + IW'(1);
  end

  // phase_idx_q doubles as the previous sample's index whenever has_prev_q is set.
  always_comb begin
    state_d     = state_q;
    phase_idx_d = phase_idx_q;
    phase_oh_d  = phase_oh_q;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;
    wrap_d      = 1'b0;
    err_cnt_d   = err_cnt_q;
    has_prev_d  = has_prev_q;
    run_d       = run_q;
    if (en) begin
      if (!legal) begin
        illegal_d  = 1'b1;
        phase_oh_d = '0;
        has_prev_d = 1'b0;
        run_d      = '0;
        state_d    = UNLOCK;
        err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      end else begin
        phase_idx_d = idx;
        phase_oh_d  = {{(TWO_N-1){1'b0}}, 1'b1} << idx;
        has_prev_d  = 1'b1;
        if (has_prev_q) begin
          if (idx == succ) begin
            run_d  = (run_q == LOCK_V) ? run_q : run_q + 4'd1;
            wrap_d = (phase_idx_q == LAST_IDX);
            if (run_d == LOCK_V) state_d = LOCK;
          end else begin
            seq_err_d = 1'b1;
            run_d     = '0;
            state_d   = UNLOCK;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCK;
      phase_idx_q <= '0;
      phase_oh_q  <= '0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
      has_prev_q  <= 1'b0;
      run_q       <= '0;
    end else begin
      state_q     <= state_d;
      phase_idx_q <= phase_idx_d;
      phase_oh_q  <= phase_oh_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
      has_prev_q  <= has_prev_d;
      run_q       <= run_d;
    end
  end

  assign phase_idx = phase_idx_q;
  assign phase_oh  = phase_oh_q;
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign wrap      = wrap_q;
  assign locked    = (state_q == LOCK);
  assign err_cnt   = err_cnt_q;

endmodule
